// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, instruction
// classes, opcode/funct values and every datapath select encoding. The
// extender, ALU and controller all import this package so they agree on codes.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        CL_ADDU  = 4'd0,
        CL_SUBU  = 4'd1,
        CL_JR    = 4'd2,
        CL_ORI   = 4'd3,
        CL_ADDIU = 4'd4,
        CL_LUI   = 4'd5,
        CL_LW    = 4'd6,
        CL_SW    = 4'd7,
        CL_BEQ   = 4'd8,
        CL_J     = 4'd9,
        CL_JAL   = 4'd10,
        CL_ILL   = 4'd11
    } iclass_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [1:0] EXT_ZERO  = 2'd0;
    localparam logic [1:0] EXT_SIGN  = 2'd1;
    localparam logic [1:0] EXT_UPPER = 2'd2;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;

    localparam logic ALU_B_REG = 1'b0;
    localparam logic ALU_B_IMM = 1'b1;

    localparam logic [1:0] RD_RT  = 2'd0;
    localparam logic [1:0] RD_RD  = 2'd1;
    localparam logic [1:0] RD_R31 = 2'd2;

    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_MEM = 2'd1;
    localparam logic [1:0] WD_PC4 = 2'd2;

    localparam logic [1:0] NPC_PC4  = 2'd0;
    localparam logic [1:0] NPC_BR   = 2'd1;
    localparam logic [1:0] NPC_JUMP = 2'd2;
    localparam logic [1:0] NPC_RS   = 2'd3;

    // ALU function for an instruction class; lui passes the upper-extended
    // immediate through an add with rs (which the encoding fixes to r0).
    function automatic logic [2:0] alu_fn(input iclass_t cls);
        case (cls)
            CL_SUBU, CL_BEQ: alu_fn = ALU_SUB;
            CL_ORI:          alu_fn = ALU_OR;
            default:         alu_fn = ALU_ADD;
        endcase
    endfunction

    function automatic logic alu_src(input iclass_t cls);
        case (cls)
            CL_ORI, CL_ADDIU, CL_LUI, CL_LW, CL_SW: alu_src = ALU_B_IMM;
            default:                                alu_src = ALU_B_REG;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Instruction decoder: maps op/funct to an instruction class, the immediate
// extender mode and an illegal-instruction flag. Purely combinational.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output iclass_t    cls,
    output logic [1:0] ext_op,
    output logic       illegal
);

    // Class lookup; anything not listed falls into CL_ILL.
    always_comb begin
        cls = CL_ILL;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: cls = CL_ADDU;
                    FN_SUBU: cls = CL_SUBU;
                    FN_JR:   cls = CL_JR;
                    default: cls = CL_ILL;
                endcase
            end
            OP_ORI:   cls = CL_ORI;
            OP_ADDIU: cls = CL_ADDIU;
            OP_LUI:   cls = CL_LUI;
            OP_LW:    cls = CL_LW;
            OP_SW:    cls = CL_SW;
            OP_BEQ:   cls = CL_BEQ;
            OP_J:     cls = CL_J;
            OP_JAL:   cls = CL_JAL;
            default:  cls = CL_ILL;
        endcase
    end

    // Extender mode depends on the opcode only.
    always_comb begin
        ext_op = EXT_ZERO;
        case (op)
            OP_ADDIU, OP_LW, OP_SW, OP_BEQ: ext_op = EXT_SIGN;
            OP_LUI:                         ext_op = EXT_UPPER;
            default:                        ext_op = EXT_ZERO;
        endcase
    end

    assign illegal = (cls == CL_ILL);

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle Moore controller: FETCH -> DECODE -> EXEC -> MEM -> WB.
// Optional performance counters are built when MC_CTRL_PERF_EN is defined.
//
// state  | meaning
// FETCH  | wait for iv, load IR and advance PC to PC+4
// DECODE | decode IR; jumps and illegal instructions finish here
// EXEC   | ALU operation; beq resolves its branch here
// MEM    | data-memory access, held until dm_ack
// WB     | single-cycle register-file write
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        iv,
    input  logic        dm_ack,
    output logic        pc_we,
    output logic        ir_we,
    output logic        reg_we,
    output logic        dm_req,
    output logic        dm_we,
    output logic        illegal,
    output logic [1:0]  ext_op,
    output logic [2:0]  alu_op,
    output logic        alu_b,
    output logic [1:0]  reg_dst,
    output logic [1:0]  wd_sel,
    output logic [1:0]  npc_sel
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] cyc_cnt,
    output logic [31:0] ret_cnt
`endif
);

    state_t     state_q;
    state_t     state_d;
    logic [5:0] op_q;
    logic [5:0] funct_q;
    logic [5:0] cur_op;
    logic [5:0] cur_funct;
    iclass_t    cls;
    logic [1:0] dec_ext;
    logic       dec_ill;

    // IR only becomes valid in DECODE, so decode the live fields there and the
    // copy captured at the end of DECODE for the remaining states.
    assign cur_op    = (state_q == ST_DECODE) ? op    : op_q;
    assign cur_funct = (state_q == ST_DECODE) ? funct : funct_q;

    mc_decode u_decode (
        .op      (cur_op),
        .funct   (cur_funct),
        .cls     (cls),
        .ext_op  (dec_ext),
        .illegal (dec_ill)
    );

    // State register and latched instruction fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            op_q    <= '0;
            funct_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                op_q    <= op;
                funct_q <= funct;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (iv) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (dec_ill) begin
                    state_d = ST_FETCH;
                end else begin
                    case (cls)
                        CL_J, CL_JAL, CL_JR: state_d = ST_FETCH;
                        default:             state_d = ST_EXEC;
                    endcase
                end
            end
            ST_EXEC: begin
                case (cls)
                    CL_BEQ:       state_d = ST_FETCH;
                    CL_LW, CL_SW: state_d = ST_MEM;
                    default:      state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (dm_ack) state_d = (cls == CL_LW) ? ST_WB : ST_FETCH;
            end
            ST_WB:   state_d = ST_FETCH;
            default: state_d = ST_FETCH;
        endcase
    end

    // Output decode; gating with rst_n drops every output the moment reset
    // asserts, including a dm_req that is mid-access.
    always_comb begin
        pc_we   = 1'b0;
        ir_we   = 1'b0;
        reg_we  = 1'b0;
        dm_req  = 1'b0;
        dm_we   = 1'b0;
        illegal = 1'b0;
        ext_op  = EXT_ZERO;
        alu_op  = ALU_ADD;
        alu_b   = ALU_B_REG;
        reg_dst = RD_RT;
        wd_sel  = WD_ALU;
        npc_sel = NPC_PC4;
        if (rst_n) begin
            case (state_q)
                ST_FETCH: begin
                    ir_we = iv;
                    pc_we = iv;
                end
                ST_DECODE: begin
                    ext_op = dec_ext;
                    if (dec_ill) begin
                        illegal = 1'b1;
                    end else begin
                        case (cls)
                            CL_J: begin
                                pc_we   = 1'b1;
                                npc_sel = NPC_JUMP;
                            end
                            CL_JAL: begin
                                pc_we   = 1'b1;
                                npc_sel = NPC_JUMP;
                                reg_we  = 1'b1;
                                reg_dst = RD_R31;
                                wd_sel  = WD_PC4;
                            end
                            CL_JR: begin
                                pc_we   = 1'b1;
                                npc_sel = NPC_RS;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_EXEC: begin
                    ext_op = dec_ext;
                    alu_op = alu_fn(cls);
                    alu_b  = alu_src(cls);
                    if (cls == CL_BEQ) begin
                        pc_we   = zero;
                        npc_sel = NPC_BR;
                    end
                end
                ST_MEM: begin
                    ext_op = dec_ext;
                    alu_op = alu_fn(cls);
                    alu_b  = alu_src(cls);
                    dm_req = 1'b1;
                    dm_we  = (cls == CL_SW);
                end
                ST_WB: begin
                    ext_op  = dec_ext;
                    alu_op  = alu_fn(cls);
                    alu_b   = alu_src(cls);
                    reg_we  = 1'b1;
                    reg_dst = (cls == CL_ADDU || cls == CL_SUBU) ? RD_RD : RD_RT;
                    wd_sel  = (cls == CL_LW) ? WD_MEM : WD_ALU;
                end
                default: ;
            endcase
        end
    end

`ifdef MC_CTRL_PERF_EN
    logic retire;

    // An instruction retires on any return to FETCH except the illegal exit.
    assign retire = (state_q != ST_FETCH) && (state_d == ST_FETCH)
                    && !((state_q == ST_DECODE) && dec_ill);

    // Free-running cycle counter and retired-instruction counter, both wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if (retire) ret_cnt <= ret_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: each instruction pushes its expected
// per-cycle output sequence onto a scoreboard, which is popped and compared
// cycle by cycle as the stimulus is applied.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  op = '0;
    logic [5:0]  funct = '0;
    logic        zero = 1'b0;
    logic        iv = 1'b0;
    logic        dm_ack = 1'b0;
    logic        pc_we, ir_we, reg_we, dm_req, dm_we, illegal;
    logic [1:0]  ext_op;
    logic [2:0]  alu_op;
    logic        alu_b;
    logic [1:0]  reg_dst, wd_sel, npc_sel;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] cyc_cnt, ret_cnt;
    int          tb_cyc = 0;
    int          tb_ret = 0;
`endif

    mc_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .op      (op),
        .funct   (funct),
        .zero    (zero),
        .iv      (iv),
        .dm_ack  (dm_ack),
        .pc_we   (pc_we),
        .ir_we   (ir_we),
        .reg_we  (reg_we),
        .dm_req  (dm_req),
        .dm_we   (dm_we),
        .illegal (illegal),
        .ext_op  (ext_op),
        .alu_op  (alu_op),
        .alu_b   (alu_b),
        .reg_dst (reg_dst),
        .wd_sel  (wd_sel),
        .npc_sel (npc_sel)
`ifdef MC_CTRL_PERF_EN
        ,
        .cyc_cnt (cyc_cnt),
        .ret_cnt (ret_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_we, ir_we, reg_we, dm_req, dm_we, illegal;
        logic [1:0] ext_op;
        logic [2:0] alu_op;
        logic       alu_b;
        logic [1:0] reg_dst, wd_sel, npc_sel;
    } outs_t;

    typedef struct {
        logic [5:0] op, funct;
        logic       iv, ack, zero, retire;
        outs_t      exp, msk;
        string      tag;
    } step_t;

    step_t sb[$];
    int    n_checks = 0;
    int    n_fail = 0;
    outs_t obs;

    assign obs = {pc_we, ir_we, reg_we, dm_req, dm_we, illegal,
                  ext_op, alu_op, alu_b, reg_dst, wd_sel, npc_sel};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        assert (got === want)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // A step with iv/dm_ack high and every strobe expected low (strobes always checked).
    function automatic step_t mk(input logic [5:0] o, input logic [5:0] f,
                                 input logic z, input string t);
        step_t s;
        s.op = o; s.funct = f; s.zero = z;
        s.iv = 1'b1; s.ack = 1'b1; s.retire = 1'b0;
        s.exp = '0;
        s.msk = outs_t'(18'h3F000);
        s.tag = t;
        return s;
    endfunction

    // Reference model: expected cycle sequence of one instruction.
    task automatic push(input logic [5:0] o, input logic [5:0] f, input logic z,
                        input int iv_wait, input int ack_wait, input string nm);
        step_t      s;
        string      k;
        logic [1:0] ext;
        k = "ill";
        case (o)
            6'h00: begin
                if (f == 6'h21) k = "addu";
                else if (f == 6'h23) k = "subu";
                else if (f == 6'h08) k = "jr";
            end
            6'h0D: k = "ori";
            6'h09: k = "addiu";
            6'h0F: k = "lui";
            6'h23: k = "lw";
            6'h2B: k = "sw";
            6'h04: k = "beq";
            6'h02: k = "j";
            6'h03: k = "jal";
            default: k = "ill";
        endcase
        ext = 2'd0;
        if (o == 6'h09 || o == 6'h23 || o == 6'h2B || o == 6'h04) ext = 2'd1;
        else if (o == 6'h0F) ext = 2'd2;

        for (int i = 0; i < iv_wait; i++) begin
            s = mk(o, f, z, {nm, ".fetch_wait"});
            s.iv = 1'b0;
            sb.push_back(s);
        end
        s = mk(o, f, z, {nm, ".fetch"});
        s.exp.pc_we = 1'b1; s.exp.ir_we = 1'b1;
        s.msk.npc_sel = '1;
        sb.push_back(s);

        s = mk(o, f, z, {nm, ".decode"});
        s.exp.ext_op = ext; s.msk.ext_op = '1;
        if (k == "j" || k == "jal" || k == "jr") begin
            s.exp.pc_we = 1'b1;
            s.exp.npc_sel = (k == "jr") ? 2'd3 : 2'd2;
            s.msk.npc_sel = '1;
            if (k == "jal") begin
                s.exp.reg_we = 1'b1; s.exp.reg_dst = 2'd2; s.exp.wd_sel = 2'd2;
                s.msk.reg_dst = '1; s.msk.wd_sel = '1;
            end
            s.retire = 1'b1;
            sb.push_back(s);
            return;
        end
        if (k == "ill") begin
            s.exp.illegal = 1'b1;
            sb.push_back(s);
            return;
        end
        sb.push_back(s);

        s = mk(o, f, z, {nm, ".exec"});
        s.exp.ext_op = ext; s.msk.ext_op = '1;
        if (k == "beq") begin
            s.exp.alu_op = 3'd1; s.msk.alu_op = '1;
            s.exp.pc_we = z;
            s.exp.npc_sel = 2'd1; s.msk.npc_sel = '1;
            s.retire = 1'b1;
            sb.push_back(s);
            return;
        end
        if (k != "lui") begin
            s.exp.alu_op = (k == "subu") ? 3'd1 : (k == "ori") ? 3'd2 : 3'd0;
            s.exp.alu_b = (k == "addu" || k == "subu") ? 1'b0 : 1'b1;
            s.msk.alu_op = '1; s.msk.alu_b = '1;
        end
        sb.push_back(s);

        if (k == "lw" || k == "sw") begin
            for (int i = 0; i <= ack_wait; i++) begin
                s = mk(o, f, z, {nm, ".mem"});
                s.ack = (i == ack_wait);
                s.exp.dm_req = 1'b1;
                s.exp.dm_we = (k == "sw");
                s.retire = (i == ack_wait) && (k == "sw");
                sb.push_back(s);
            end
            if (k == "sw") return;
        end

        s = mk(o, f, z, {nm, ".wb"});
        s.exp.reg_we = 1'b1;
        s.exp.reg_dst = (k == "addu" || k == "subu") ? 2'd1 : 2'd0;
        s.exp.wd_sel = (k == "lw") ? 2'd1 : 2'd0;
        s.msk.reg_dst = '1; s.msk.wd_sel = '1;
        s.retire = 1'b1;
        sb.push_back(s);
    endtask

    // Drain up to n scoreboard entries, one clock cycle each.
    task automatic run(input int n);
        step_t s;
        for (int i = 0; i < n && sb.size() > 0; i++) begin
            s = sb.pop_front();
            op = s.op; funct = s.funct; iv = s.iv; dm_ack = s.ack; zero = s.zero;
            #2;
            check(s.tag, 32'(obs & s.msk), 32'(s.exp & s.msk));
            @(posedge clk);
            #1;
`ifdef MC_CTRL_PERF_EN
            tb_cyc++;
            if (s.retire) tb_ret++;
`endif
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; iv = 1'b1; dm_ack = 1'b1; op = 6'h0D;
        #12;
        check("reset_outputs", 32'(obs), 32'd0);
        @(posedge clk); #3;
        check("reset_hold", 32'(obs), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        push(6'h0D, 6'h00, 1'b0, 0, 0, "ori");
        push(6'h0F, 6'h00, 1'b0, 0, 0, "lui");
        push(6'h09, 6'h00, 1'b0, 0, 0, "addiu");
        push(6'h00, 6'h21, 1'b0, 0, 0, "addu");
        push(6'h00, 6'h23, 1'b0, 0, 0, "subu");
        push(6'h23, 6'h00, 1'b0, 0, 3, "lw");
        push(6'h2B, 6'h00, 1'b0, 0, 0, "sw");
        push(6'h04, 6'h00, 1'b1, 0, 0, "beq_taken");
        push(6'h04, 6'h00, 1'b0, 0, 0, "beq_not");
        push(6'h02, 6'h00, 1'b0, 0, 0, "j");
        push(6'h03, 6'h00, 1'b0, 0, 0, "jal");
        push(6'h00, 6'h08, 1'b0, 0, 0, "jr");
        push(6'h3F, 6'h00, 1'b0, 0, 0, "ill_op");
        push(6'h00, 6'h3F, 1'b0, 0, 0, "ill_funct");
        push(6'h0D, 6'h00, 1'b0, 2, 0, "ori_ivwait");
        run(sb.size());
`ifdef MC_CTRL_PERF_EN
        check("ret_cnt", ret_cnt, 32'(tb_ret));
        check("cyc_cnt", cyc_cnt, 32'(tb_cyc));
`endif

        // Asynchronous reset during a sw access that is still waiting for dm_ack.
        push(6'h2B, 6'h00, 1'b0, 0, 5, "sw_rst");
        run(4);
        op = 6'h2B; iv = 1'b1; dm_ack = 1'b0;
        #2;
        check("sw_mem_active", 32'({dm_req, dm_we}), 32'd3);
        rst_n = 1'b0;
        #1;
        check("rst_drops_dm", 32'({dm_req, dm_we}), 32'd0);
        check("rst_all_zero", 32'(obs), 32'd0);
        sb.delete();
        @(posedge clk); #2;
        check("rst_hold_iv", 32'(obs), 32'd0);
`ifdef MC_CTRL_PERF_EN
        check("rst_cyc_cnt", cyc_cnt, 32'd0);
        check("rst_ret_cnt", ret_cnt, 32'd0);
        tb_cyc = 0;
        tb_ret = 0;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        push(6'h03, 6'h00, 1'b0, 0, 0, "jal_after_rst");
        push(6'h23, 6'h00, 1'b0, 1, 0, "lw_after_rst");
        run(sb.size());
`ifdef MC_CTRL_PERF_EN
        check("ret_cnt2", ret_cnt, 32'(tb_ret));
        iv = 1'b0;
        force dut.cyc_cnt = 32'hFFFF_FFFE;
        @(posedge clk); #1;
        release dut.cyc_cnt;
        #1;
        check("cyc_preset", cyc_cnt, 32'hFFFF_FFFE);
        @(posedge clk); #1;
        check("cyc_max", cyc_cnt, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        check("cyc_wrap", cyc_cnt, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
